// File: rtl/cmos_capture_pkg.sv
// Shared constants, FSM encoding and pixel payload type for the CMOS capture block.
package cmos_pkg;

    localparam int unsigned H_ACTIVE_DEF    = 640;
    localparam int unsigned V_ACTIVE_DEF    = 480;
    localparam int unsigned SKIP_FRAMES_DEF = 10;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned PIX_W       = 16;
    localparam int unsigned CNT_W       = 11;
    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned SKIP_CNT_W  = 16;

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        WAIT_VS  = 2'd1,
        SKIP     = 2'd2,
        CAPTURE  = 2'd3
    } cap_state_e;

    // RGB565 pixel as it arrives on the byte bus: high byte first
    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } pixel_t;

    // Saturating increment for the 11-bit line/pixel counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cmos_capture_if.sv
// Camera byte bus in, packed pixel stream out.
interface cmos_capture_if;
    import cmos_pkg::*;

    logic              cmos_vsyn;
    logic              cmos_href;
    logic [BYTE_W-1:0] cmos_data;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;

    // Sensor/system side: drives the camera pins, consumes pixels
    modport master (
        output cmos_vsyn,
        output cmos_href,
        output cmos_data,
        input  pix_data,
        input  pix_valid
    );

    // Capture block side
    modport slave (
        input  cmos_vsyn,
        input  cmos_href,
        input  cmos_data,
        output pix_data,
        output pix_valid
    );

endinterface

// File: rtl/cmos_capture_byte_packer.sv
// Stage-1 pin registers, edge detection and byte-pair to RGB565 packing.
module cmos_byte_packer
    import cmos_pkg::*;
(
    input  logic              cmos_pclk,
    input  logic              rst_pclk,
    input  logic              cmos_vsyn,
    input  logic              cmos_href,
    input  logic [BYTE_W-1:0] cmos_data,
    input  logic              capture_en,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              line_armed,
    output logic              vsyn_rise_c,
    output logic              vsyn_fall_c,
    output logic              href_fall_c,
    output logic              pix_stb_c,
    output logic              dangling_c
);

    logic              vsyn_s1;
    logic              href_s1;
    logic [BYTE_W-1:0] data_s1;
    logic              vsyn_s2;
    logic              href_s2;
    logic              byte_phase;
    logic [BYTE_W-1:0] hi_byte;
    pixel_t            pix_q;
    logic              byte_take_c;

    // Register the pins once; keep one cycle of history for edge detection
    always_ff @(posedge cmos_pclk) begin
        if (rst_pclk) begin
            vsyn_s1 <= 1'b0;
            href_s1 <= 1'b0;
            data_s1 <= '0;
            vsyn_s2 <= 1'b0;
            href_s2 <= 1'b0;
        end else begin
            vsyn_s1 <= cmos_vsyn;
            href_s1 <= cmos_href;
            data_s1 <= cmos_data;
            vsyn_s2 <= vsyn_s1;
            href_s2 <= href_s1;
        end
    end

    assign vsyn_rise_c = vsyn_s1 & ~vsyn_s2;
    assign vsyn_fall_c = ~vsyn_s1 & vsyn_s2;
    assign href_fall_c = ~href_s1 & href_s2;

    // A byte is taken only on a line that started inside the captured frame
    assign byte_take_c = capture_en & line_armed & href_s1;
    assign pix_stb_c   = byte_take_c & byte_phase;
    // Even byte held but href already gone: the pixel can never complete
    assign dangling_c  = byte_phase & ~href_s1;

    // Arm only after href is seen low in capture, so a line in progress at frame entry is ignored
    always_ff @(posedge cmos_pclk) begin
        if (rst_pclk) begin
            line_armed <= 1'b0;
        end else if (!capture_en) begin
            line_armed <= 1'b0;
        end else if (!href_s1) begin
            line_armed <= 1'b1;
        end
    end

    // Even byte to the high half, odd byte completes the pixel
    always_ff @(posedge cmos_pclk) begin
        if (rst_pclk) begin
            byte_phase <= 1'b0;
            hi_byte    <= '0;
            pix_q      <= '0;
            pix_valid  <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            if (!byte_take_c) begin
                byte_phase <= 1'b0;
            end else if (!byte_phase) begin
                hi_byte    <= data_s1;
                byte_phase <= 1'b1;
            end else begin
                pix_q.hi   <= hi_byte;
                pix_q.lo   <= data_s1;
                pix_valid  <= 1'b1;
                byte_phase <= 1'b0;
            end
        end
    end

    assign pix_data = pix_q;

endmodule

// File: rtl/cmos_capture.sv
// Frame capture control: start-up skip, frame/line bookkeeping and length checking.
module cmos_capture
    import cmos_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned SKIP_FRAMES = SKIP_FRAMES_DEF
)
(
    input  logic                   cmos_pclk,
    input  logic                   rst_pclk,
    input  logic                   cfg_done,
    cmos_capture_if.slave          cam,
    output logic                   frame_start,
    output logic                   frame_done,
    output logic [CNT_W-1:0]       line_cnt,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_sticky
);

    cap_state_e             state_q;
    cap_state_e             state_nxt;
    logic [SKIP_CNT_W-1:0]  skip_cnt;
    logic [CNT_W-1:0]       pix_cnt;
    logic [CNT_W-1:0]       line_cnt_eff;

    logic capture_en_c;
    logic frame_start_c;
    logic frame_end_c;
    logic skip_inc_c;
    logic line_end_c;

    logic line_armed;
    logic vsyn_rise_c;
    logic vsyn_fall_c;
    logic href_fall_c;
    logic pix_stb_c;
    logic dangling_c;

    // Pin staging and pixel packing
    cmos_byte_packer u_packer (
        .cmos_pclk   (cmos_pclk),
        .rst_pclk    (rst_pclk),
        .cmos_vsyn   (cam.cmos_vsyn),
        .cmos_href   (cam.cmos_href),
        .cmos_data   (cam.cmos_data),
        .capture_en  (capture_en_c),
        .pix_data    (cam.pix_data),
        .pix_valid   (cam.pix_valid),
        .line_armed  (line_armed),
        .vsyn_rise_c (vsyn_rise_c),
        .vsyn_fall_c (vsyn_fall_c),
        .href_fall_c (href_fall_c),
        .pix_stb_c   (pix_stb_c),
        .dangling_c  (dangling_c)
    );

    // FSM state register
    always_ff @(posedge cmos_pclk) begin
        if (rst_pclk) begin
            state_q <= WAIT_CFG;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state; losing configuration overrides everything
    always_comb begin
        state_nxt = state_q;
        if (!cfg_done) begin
            state_nxt = WAIT_CFG;
        end else begin
            case (state_q)
                WAIT_CFG: state_nxt = WAIT_VS;
                WAIT_VS: begin
                    if (vsyn_fall_c) begin
                        state_nxt = (skip_cnt < SKIP_CNT_W'(SKIP_FRAMES)) ? SKIP : CAPTURE;
                    end
                end
                SKIP:     if (vsyn_rise_c) state_nxt = WAIT_VS;
                CAPTURE:  if (vsyn_rise_c) state_nxt = WAIT_VS;
                default:  state_nxt = WAIT_CFG;
            endcase
        end
    end

    // FSM decodes; capture enable looks at the next state so pix_valid never outlives CAPTURE
    always_comb begin
        capture_en_c  = 1'b0;
        frame_start_c = 1'b0;
        frame_end_c   = 1'b0;
        skip_inc_c    = 1'b0;
        line_end_c    = 1'b0;
        capture_en_c  = (state_nxt == CAPTURE);
        frame_start_c = (state_q == WAIT_VS) && (state_nxt == CAPTURE);
        frame_end_c   = (state_q == CAPTURE) && (state_nxt == WAIT_VS);
        skip_inc_c    = (state_q == SKIP) && (state_nxt == WAIT_VS);
        line_end_c    = (state_q == CAPTURE) && href_fall_c && line_armed;
    end

    // A line ending in the same cycle as the frame is counted before the frame check
    assign line_cnt_eff = line_end_c ? sat_inc(line_cnt) : line_cnt;

    // Skip counter, cleared whenever configuration is lost
    always_ff @(posedge cmos_pclk) begin
        if (rst_pclk) begin
            skip_cnt <= '0;
        end else if (!cfg_done) begin
            skip_cnt <= '0;
        end else if (skip_inc_c && (skip_cnt < SKIP_CNT_W'(SKIP_FRAMES))) begin
            skip_cnt <= skip_cnt + SKIP_CNT_W'(1);
        end
    end

    // Pixels in the current line
    always_ff @(posedge cmos_pclk) begin
        if (rst_pclk) begin
            pix_cnt <= '0;
        end else if (frame_start_c || href_fall_c) begin
            pix_cnt <= '0;
        end else if (pix_stb_c) begin
            pix_cnt <= sat_inc(pix_cnt);
        end
    end

    // Frame pulses, line/frame counters and sticky length error
    always_ff @(posedge cmos_pclk) begin
        if (rst_pclk) begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_cnt    <= '0;
            frame_cnt   <= '0;
            err_sticky  <= 1'b0;
        end else begin
            frame_start <= frame_start_c;
            frame_done  <= frame_end_c;
            if (frame_start_c) begin
                line_cnt <= '0;
            end else begin
                line_cnt <= line_cnt_eff;
            end
            if (frame_end_c) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
            if (line_end_c && (pix_cnt != CNT_W'(H_ACTIVE))) begin
                err_sticky <= 1'b1;
            end
            if (dangling_c) begin
                err_sticky <= 1'b1;
            end
            if (frame_end_c && (line_cnt_eff != CNT_W'(V_ACTIVE))) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmos_capture.sv
// Self-checking bench for cmos_capture: scoreboard of expected pixels plus frame-level checks.
module tb_cmos_capture;
    import cmos_pkg::*;

    localparam int unsigned H    = 8;
    localparam int unsigned V    = 4;
    localparam int unsigned SKIP_N = 2;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        cmos_pclk = 1'b0;
    logic        rst_pclk;
    logic        cfg_done;
    logic        frame_start;
    logic        frame_done;
    logic [10:0] line_cnt;
    logic [15:0] frame_cnt;
    logic        err_sticky;

    cmos_capture_if cam();

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   pv_cnt  = 0;
    int   fs_cnt  = 0;
    int   fd_cnt  = 0;
    int   skips_left;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 cmos_pclk = ~cmos_pclk;

    always @(posedge cmos_pclk) cyc <= cyc + 1;

    cmos_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SKIP_FRAMES (SKIP_N)
    ) dut (
        .cmos_pclk   (cmos_pclk),
        .rst_pclk    (rst_pclk),
        .cfg_done    (cfg_done),
        .cam         (cam),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .line_cnt    (line_cnt),
        .frame_cnt   (frame_cnt),
        .err_sticky  (err_sticky)
    );

    task automatic tb_check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Pop one expectation per pix_valid; data and pin-to-output latency must match
    always @(negedge cmos_pclk) begin
        if (pix_valid_seen()) begin
            pv_cnt++;
            if (sb_q.size() == 0) begin
                tb_check("unexpected_pix", 32'(cam.pix_data), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                tb_check("pix_data", 32'(cam.pix_data), 32'(mon_e.data));
                tb_check("pix_latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        if (frame_start === 1'b1) fs_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
    end

    function automatic bit pix_valid_seen();
        return cam.pix_valid === 1'b1;
    endfunction

    task automatic check_outputs_zero(input string pfx);
        tb_check({pfx, "_pix_data"},    32'(cam.pix_data), 32'h0);
        tb_check({pfx, "_pix_valid"},   32'(cam.pix_valid), 32'h0);
        tb_check({pfx, "_frame_start"}, 32'(frame_start), 32'h0);
        tb_check({pfx, "_frame_done"},  32'(frame_done), 32'h0);
        tb_check({pfx, "_line_cnt"},    32'(line_cnt), 32'h0);
        tb_check({pfx, "_frame_cnt"},   32'(frame_cnt), 32'h0);
        tb_check({pfx, "_err_sticky"},  32'(err_sticky), 32'h0);
    endtask

    // One camera frame; abort_kind 1 drops cfg_done, 2 pulses reset, at the given line/byte
    task automatic send_frame(input int lines, input int short_line, input int short_bytes,
                              input int abort_kind, input int abort_line, input int abort_byte);
        bit          cap;
        bit          aborted;
        int          nb;
        logic [7:0]  b;
        logic [7:0]  hi;
        cap     = (skips_left == 0);
        aborted = 1'b0;
        hi      = 8'h00;
        if (!cap) skips_left--;
        repeat (4) begin
            @(negedge cmos_pclk);
            cam.cmos_vsyn = 1'b1;
            cam.cmos_href = 1'b0;
        end
        @(negedge cmos_pclk);
        cam.cmos_vsyn = 1'b0;
        repeat (3) @(negedge cmos_pclk);
        for (int l = 0; l < lines; l++) begin
            nb = (l == short_line) ? short_bytes : int'(2 * H);
            for (int i = 0; i < nb; i++) begin
                @(negedge cmos_pclk);
                if (rst_pclk) begin
                    check_outputs_zero("midline_rst");
                    rst_pclk = 1'b0;
                end
                if (abort_kind != 0 && l == abort_line && i == abort_byte) begin
                    aborted = 1'b1;
                    cap     = 1'b0;
                    if (abort_kind == 1) cfg_done = 1'b0;
                    else                 rst_pclk = 1'b1;
                end
                if (l == 0 && i < 2) b = (i == 0) ? 8'hF8 : 8'h1F;
                else                 b = 8'($urandom);
                cam.cmos_href = 1'b1;
                cam.cmos_data = b;
                if (i % 2 == 0) hi = b;
                else if (cap) sb_q.push_back('{data: {hi, b}, cyc: cyc + 2});
            end
            @(negedge cmos_pclk);
            cam.cmos_href = 1'b0;
            cam.cmos_data = 8'h00;
            repeat (3) @(negedge cmos_pclk);
        end
        @(negedge cmos_pclk);
        cam.cmos_vsyn = 1'b1;
        repeat (4) @(negedge cmos_pclk);
        if (aborted) begin
            // at most the pixel already in the pipe at the abort may have been lost
            tb_check("abort_inflight", 32'(sb_q.size() <= 1), 32'h1);
            sb_q.delete();
            cfg_done   = 1'b1;
            skips_left = SKIP_N;
            repeat (2) @(negedge cmos_pclk);
        end else begin
            tb_check("sb_drained", 32'(sb_q.size()), 32'h0);
        end
    endtask

    initial begin
        int fd0;
        rst_pclk      = 1'b1;
        cfg_done      = 1'b0;
        cam.cmos_vsyn = 1'b1;
        cam.cmos_href = 1'b0;
        cam.cmos_data = 8'h00;
        skips_left    = SKIP_N;
        repeat (3) @(negedge cmos_pclk);
        check_outputs_zero("reset");
        rst_pclk = 1'b0;
        @(negedge cmos_pclk);
        cfg_done = 1'b1;
        repeat (4) @(negedge cmos_pclk);

        // Two skipped frames then two captured 4x8 frames; first pixel of each is F8,1F
        for (int f = 0; f < 4; f++) begin
            pv_cnt = 0;
            send_frame(V, -1, 0, 0, 0, 0);
            tb_check($sformatf("s1_pix_count_f%0d", f), 32'(pv_cnt), (f < 2) ? 32'd0 : 32'd32);
        end
        tb_check("s1_frame_cnt", 32'(frame_cnt), 32'd2);
        tb_check("s1_err", 32'(err_sticky), 32'd0);
        tb_check("s1_line_cnt", 32'(line_cnt), 32'd4);
        tb_check("s1_frame_starts", 32'(fs_cnt), 32'd2);
        tb_check("s1_frame_dones", 32'(fd_cnt), 32'd2);

        // Odd-length line: 15 bytes give 7 pixels and a length error
        pv_cnt = 0;
        send_frame(V, 1, 15, 0, 0, 0);
        tb_check("s3_pix_count", 32'(pv_cnt), 32'd31);
        tb_check("s3_err", 32'(err_sticky), 32'd1);
        tb_check("s3_frame_cnt", 32'(frame_cnt), 32'd3);

        // Reset pulse mid-line, then full skip sequence before capture resumes
        send_frame(V, -1, 0, 2, 1, 6);
        tb_check("s6_frame_cnt", 32'(frame_cnt), 32'd0);
        for (int f = 0; f < 3; f++) begin
            pv_cnt = 0;
            send_frame(V, -1, 0, 0, 0, 0);
            tb_check($sformatf("s6_pix_count_f%0d", f), 32'(pv_cnt), (f < 2) ? 32'd0 : 32'd32);
        end
        tb_check("s6_err", 32'(err_sticky), 32'd0);
        tb_check("s6_frame_cnt_after", 32'(frame_cnt), 32'd1);

        // cfg_done lost mid-capture: no frame_done, skips redone after it returns
        fd0 = fd_cnt;
        send_frame(V, -1, 0, 1, 2, 4);
        tb_check("s5_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        tb_check("s5_frame_cnt", 32'(frame_cnt), 32'd1);
        for (int f = 0; f < 3; f++) begin
            pv_cnt = 0;
            send_frame(V, -1, 0, 0, 0, 0);
            tb_check($sformatf("s5_pix_count_f%0d", f), 32'(pv_cnt), (f < 2) ? 32'd0 : 32'd32);
        end
        tb_check("s5_frame_cnt_after", 32'(frame_cnt), 32'd2);
        tb_check("s5_err", 32'(err_sticky), 32'd0);

        // Short frame: 3 of 4 lines
        fd0    = fd_cnt;
        pv_cnt = 0;
        send_frame(3, -1, 0, 0, 0, 0);
        tb_check("s4_pix_count", 32'(pv_cnt), 32'd24);
        tb_check("s4_frame_done", 32'(fd_cnt - fd0), 32'd1);
        tb_check("s4_line_cnt", 32'(line_cnt), 32'd3);
        tb_check("s4_err", 32'(err_sticky), 32'd1);
        tb_check("s4_frame_cnt", 32'(frame_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/cmos_capture.md
CMOS_CAPTURE -- requirements
Module: cmos_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL set the expected pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, SHALL set the expected lines per frame.
REQ-003 Parameter SKIP_FRAMES, default 10, SHALL set the frames discarded after cfg_done.
REQ-004 cmos_pclk  in  1: sole clock; all logic on its rising edge.
REQ-005 rst_pclk  in  1: reset, synchronous, active-high.
REQ-006 cfg_done  in  1: camera register configuration complete; level signal, synchronised externally.
REQ-007 cmos_vsyn  in  1: camera frame sync; high marks the inter-frame gap.
REQ-008 cmos_href  in  1: camera line valid; bytes are valid while high.
REQ-009 cmos_data  in  8: camera byte bus, RGB565, high byte first.
REQ-010 pix_data  out  16: packed RGB565 pixel, {first byte, second byte}.
REQ-011 pix_valid  out  1: one-cycle strobe; pix_data valid (FIFO write enable).
REQ-012 frame_start  out  1: one-cycle pulse at the start of each captured frame.
REQ-013 frame_done  out  1: one-cycle pulse at the end of each captured frame.
REQ-014 line_cnt  out  11: lines completed in the current frame.
REQ-015 frame_cnt  out  16: captured frames since reset; wraps 65535->0.
REQ-016 err_sticky  out  1: set on any line or frame length mismatch; cleared only by reset.

Function
REQ-017 cmos_vsyn, cmos_href and cmos_data SHALL each be registered once (stage 1); all decisions SHALL use the stage-1 values.
REQ-018 The FSM SHALL have states WAIT_CFG, WAIT_VS, SKIP, CAPTURE.
REQ-019 WAIT_CFG->WAIT_VS when cfg_done=1.
REQ-020 WAIT_VS->SKIP on a vsyn falling edge (stage-1 1->0) while skip_cnt<SKIP_FRAMES; WAIT_VS->CAPTURE on a vsyn falling edge while skip_cnt==SKIP_FRAMES.
REQ-021 SKIP SHALL increment skip_cnt and return to WAIT_VS on the next vsyn rising edge; skip_cnt saturates at SKIP_FRAMES.
REQ-022 CAPTURE SHALL pulse frame_start in the cycle the falling edge is detected.
REQ-023 On a vsyn rising edge in CAPTURE, the block SHALL pulse frame_done, increment frame_cnt, and go to WAIT_VS.
REQ-024 cfg_done falling to 0 in any state SHALL force WAIT_CFG and clear skip_cnt on the next edge.
REQ-025 In CAPTURE, with href high, a byte phase toggle SHALL capture the even byte into the high half and the odd byte into the low half.
REQ-026 pix_valid SHALL assert the cycle after the odd byte is in stage 1, giving a pin-to-pix_valid latency of 2 cycles.
REQ-027 pix_valid SHALL never assert outside CAPTURE.
REQ-028 The byte phase SHALL clear whenever href is low.
REQ-029 A dangling even byte at an href falling edge SHALL be dropped and SHALL set err_sticky.
REQ-030 An 11-bit pix_cnt SHALL count pixels per line.
REQ-031 On an href falling edge, pix_cnt!=H_ACTIVE SHALL set err_sticky; line_cnt SHALL then increment and pix_cnt SHALL clear.
REQ-032 pix_cnt SHALL saturate at 2047.
REQ-033 At frame_done, line_cnt!=V_ACTIVE SHALL set err_sticky.
REQ-034 line_cnt SHALL clear at frame_start.
REQ-035 line_cnt SHALL saturate at 2047.
REQ-036 If an href falling edge and a vsyn rising edge occur in the same cycle, the line SHALL be counted before the frame check.
REQ-037 A frame entered mid-line (href high at the vsyn fall) SHALL have that partial line ignored: no pix_valid until href is first seen low.

Reset
REQ-038 rst_pclk=1 SHALL set state=WAIT_CFG, pix_data=0, pix_valid=0, frame_start=0, frame_done=0, line_cnt=0, frame_cnt=0, err_sticky=0, skip_cnt=0, byte phase=0, and all stage-1 registers=0.
REQ-039 Reset asserted mid-line SHALL abort the line with no further pix_valid; capture SHALL restart only after cfg_done and SKIP_FRAMES.

Structure
REQ-040 Package cmos_pkg SHALL hold the FSM state encoding and the default H_ACTIVE/V_ACTIVE/SKIP_FRAMES constants.
REQ-041 One sub-module, cmos_byte_packer (stage-1 registers, byte phase, pix_data/pix_valid), SHALL be used; the FSM and counters SHALL stay in cmos_capture.

Verification
REQ-042 Scenario 1: SKIP_FRAMES=2, cfg_done=1, 4 frames of 4 lines x 8 pixels -> frames 1-2 produce no pix_valid; frames 3-4 produce 32 pix_valid each; frame_cnt=2; err_sticky=0.
REQ-043 Scenario 2: bytes 0xF8,0x1F -> pix_data=16'hF81F with pix_valid exactly 2 cycles after the 0x1F byte on the pins.
REQ-044 Scenario 3: a 15-byte line (odd length) -> 7 pix_valid; err_sticky=1.
REQ-045 Scenario 4: V_ACTIVE=4 with only 3 lines sent -> frame_done pulses; line_cnt=3; err_sticky=1.
REQ-046 Scenario 5: cfg_done dropped mid-CAPTURE -> pix_valid stops within 1 cycle, state=WAIT_CFG, and SKIP_FRAMES skips are redone after cfg_done returns.
REQ-047 Scenario 6: rst_pclk pulsed 1 cycle mid-line -> all outputs 0 the next cycle; no pix_valid until a full skip sequence completes.
